// File: rtl/hyperbus_arb_pkg.sv
// Shared types for the two-port HyperBus arbiter: FSM state encoding,
// the port index type and the round-robin pointer reset value.
package hyperbus_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_XFER  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_ERROR = 4'b1000
  } arb_state_t;

  typedef logic port_idx_t;

  // Pointer starts at port 1 so that port 0 wins the first contention.
  localparam port_idx_t PTR_RST = 1'b1;

endpackage

// File: rtl/hyperbus_rr_arb.sv
// Combinational 2-way round-robin picker; the last-grant pointer is held
// by the caller.
module hyperbus_rr_arb
  import hyperbus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last == 1'b1)) gnt = 2'b01;
    else if (req[1])                         gnt = 2'b10;
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and burst sequencer for the hyperbus controller.
// Optional XFER watchdog enabled by defining HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter
  import hyperbus_arb_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int ADDR_LENGTH   = 32,
  parameter  int BURST_WIDTH   = 4,
  parameter  int TIMEOUT_COUNT = 64,
  localparam int DW            = 2*WIDTH,
  localparam int MW            = (2*WIDTH/8)+1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic                   m0_reg_space,
  input  logic [ADDR_LENGTH-1:0] m0_adr,
  input  logic [BURST_WIDTH-1:0] m0_len,
  input  logic [DW-1:0]          m0_wdat,
  input  logic [MW-1:0]          m0_wmask,
  output logic                   m0_wready,
  output logic [DW-1:0]          m0_rdat,
  output logic                   m0_rvalid,
  output logic                   m0_gnt,
  output logic                   m0_done,
  output logic                   m0_err,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic                   m1_reg_space,
  input  logic [ADDR_LENGTH-1:0] m1_adr,
  input  logic [BURST_WIDTH-1:0] m1_len,
  input  logic [DW-1:0]          m1_wdat,
  input  logic [MW-1:0]          m1_wmask,
  output logic                   m1_wready,
  output logic [DW-1:0]          m1_rdat,
  output logic                   m1_rvalid,
  output logic                   m1_gnt,
  output logic                   m1_done,
  output logic                   m1_err,
  output logic [ADDR_LENGTH-1:0] hb_adr_o,
  output logic [DW-1:0]          hb_dat_o,
  output logic [MW-1:0]          hb_mask_o,
  output logic                   hb_reg_space_o,
  output logic                   hb_wrq_o,
  output logic                   hb_rrq_o,
  input  logic [DW-1:0]          hb_dat_i,
  input  logic                   hb_ready_i,
  input  logic                   hb_valid_i,
  input  logic                   hb_busy_i,
  input  logic                   hb_error_i,
  output logic                   err_o
);

  if (TIMEOUT_COUNT < 2) begin : g_bad_cfg
    $error("hyperbus_arbiter: TIMEOUT_COUNT must be at least 2");
  end

  arb_state_t             state;
  port_idx_t              owner;
  port_idx_t              last_gnt;
  logic [1:0]             gnt_q;
  logic [1:0]             done_q;
  logic [1:0]             err_q;
  logic                   we_q;
  logic [BURST_WIDTH-1:0] cnt;
  logic [1:0]             pick;
  logic                   in_xfer;
  logic                   word;
  logic                   timeout;
  logic                   abort_q;
  logic                   sel_we;
  logic                   sel_reg;
  logic [ADDR_LENGTH-1:0] sel_adr;
  logic [BURST_WIDTH-1:0] sel_len;

  hyperbus_rr_arb u_rr (
    .req  ({m1_req, m0_req}),
    .last (last_gnt),
    .gnt  (pick)
  );

  assign sel_we  = pick[1] ? m1_we        : m0_we;
  assign sel_reg = pick[1] ? m1_reg_space : m0_reg_space;
  assign sel_adr = pick[1] ? m1_adr       : m0_adr;
  assign sel_len = pick[1] ? m1_len       : m0_len;

  assign in_xfer = (state == ST_XFER);
  assign word    = in_xfer && (we_q ? hb_ready_i : hb_valid_i);

  // Strobes are gated by XFER so words beyond the burst never reach a port.
  assign m0_wready = hb_ready_i & gnt_q[0] & in_xfer &  we_q;
  assign m1_wready = hb_ready_i & gnt_q[1] & in_xfer &  we_q;
  assign m0_rvalid = hb_valid_i & gnt_q[0] & in_xfer & ~we_q;
  assign m1_rvalid = hb_valid_i & gnt_q[1] & in_xfer & ~we_q;
  assign m0_rdat   = hb_dat_i;
  assign m1_rdat   = hb_dat_i;
  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];

  always_comb begin
    hb_dat_o  = '0;
    hb_mask_o = '0;
    if (gnt_q[0]) begin
      hb_dat_o  = m0_wdat;
      hb_mask_o = m0_wmask;
    end else if (gnt_q[1]) begin
      hb_dat_o  = m1_wdat;
      hb_mask_o = m1_wmask;
    end
  end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_COUNT + 1);
  logic [WD_W-1:0] wdog;

  // Fires on the TIMEOUT_COUNT-th consecutive XFER cycle without a word.
  assign timeout = in_xfer && !word && (wdog == WD_W'(TIMEOUT_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog    <= '0;
      abort_q <= 1'b0;
    end else begin
      if (!in_xfer || word) wdog <= '0;
      else                  wdog <= wdog + WD_W'(1);
      if (timeout)                abort_q <= 1'b1;
      else if (state == ST_IDLE)  abort_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      owner          <= 1'b0;
      last_gnt       <= PTR_RST;
      gnt_q          <= 2'b00;
      done_q         <= 2'b00;
      err_q          <= 2'b00;
      we_q           <= 1'b0;
      cnt            <= '0;
      hb_adr_o       <= '0;
      hb_reg_space_o <= 1'b0;
      hb_wrq_o       <= 1'b0;
      hb_rrq_o       <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      if (hb_error_i && state != ST_ERROR) begin
        hb_wrq_o <= 1'b0;
        hb_rrq_o <= 1'b0;
        gnt_q    <= 2'b00;
        err_o    <= 1'b1;
        state    <= ST_ERROR;
        if (state == ST_XFER || state == ST_DRAIN) begin
          done_q[owner] <= 1'b1;
          err_q[owner]  <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_IDLE: if (|pick) begin
            owner          <= pick[1];
            gnt_q          <= pick;
            we_q           <= sel_we;
            hb_reg_space_o <= sel_reg;
            hb_adr_o       <= sel_adr;
            cnt            <= sel_len;
            hb_wrq_o       <= sel_we;
            hb_rrq_o       <= !sel_we;
            state          <= ST_XFER;
          end
          ST_XFER: if (word) begin
            if (cnt == '0) begin
              hb_wrq_o <= 1'b0;
              hb_rrq_o <= 1'b0;
              state    <= ST_DRAIN;
            end else begin
              cnt <= cnt - BURST_WIDTH'(1);
            end
          end else if (timeout) begin
            hb_wrq_o <= 1'b0;
            hb_rrq_o <= 1'b0;
            state    <= ST_DRAIN;
          end
          ST_DRAIN: if (!hb_busy_i) begin
            done_q[owner] <= 1'b1;
            err_q[owner]  <= abort_q;
            gnt_q         <= 2'b00;
            last_gnt      <= owner;
            state         <= ST_IDLE;
          end
          ST_ERROR: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Randomized self-checking bench for hyperbus_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_hyperbus_arbiter;
  localparam int AW = 32, BW = 4, TO = 64, DW = 16, MW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_reg_space, m1_req, m1_we, m1_reg_space;
  logic [AW-1:0] m0_adr, m1_adr, hb_adr_o;
  logic [BW-1:0] m0_len, m1_len;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, hb_dat_o, hb_dat_i;
  logic [MW-1:0] m0_wmask, m1_wmask, hb_mask_o;
  logic m0_wready, m0_rvalid, m0_gnt, m0_done, m0_err;
  logic m1_wready, m1_rvalid, m1_gnt, m1_done, m1_err;
  logic hb_reg_space_o, hb_wrq_o, hb_rrq_o, err_o;
  logic hb_ready_i, hb_valid_i, hb_busy_i, hb_error_i;

  hyperbus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_reg_space(m0_reg_space), .m0_adr(m0_adr),
    .m0_len(m0_len), .m0_wdat(m0_wdat), .m0_wmask(m0_wmask), .m0_wready(m0_wready),
    .m0_rdat(m0_rdat), .m0_rvalid(m0_rvalid), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_reg_space(m1_reg_space), .m1_adr(m1_adr),
    .m1_len(m1_len), .m1_wdat(m1_wdat), .m1_wmask(m1_wmask), .m1_wready(m1_wready),
    .m1_rdat(m1_rdat), .m1_rvalid(m1_rvalid), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
    .hb_adr_o(hb_adr_o), .hb_dat_o(hb_dat_o), .hb_mask_o(hb_mask_o),
    .hb_reg_space_o(hb_reg_space_o), .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o),
    .hb_dat_i(hb_dat_i), .hb_ready_i(hb_ready_i), .hb_valid_i(hb_valid_i),
    .hb_busy_i(hb_busy_i), .hb_error_i(hb_error_i), .err_o(err_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Transaction-level reference: phase 0 idle, 1 moving words, 2 waiting for busy, 3 error.
  int            md_phase, md_owner, md_left, md_ptr;
  bit            md_granted, md_we, md_reg, md_err_sticky;
  logic [AW-1:0] md_adr;
  bit   [1:0]    md_done, md_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_phase = 0; md_owner = 0; md_left = 0; md_ptr = 1; md_granted = 0;
      md_we = 0; md_reg = 0; md_adr = '0; md_done = 0; md_err = 0; md_err_sticky = 0;
    end else begin
      md_done = 0; md_err = 0;
      if (hb_error_i && md_phase != 3) begin
        if (md_granted) begin md_done[md_owner] = 1; md_err[md_owner] = 1; end
        md_granted = 0; md_phase = 3; md_err_sticky = 1;
      end else if (md_phase == 0) begin
        if (m0_req || m1_req) begin
          md_owner = (m0_req && m1_req) ? 1 - md_ptr : (m0_req ? 0 : 1);
          md_we   = (md_owner == 0) ? m0_we : m1_we;
          md_reg  = (md_owner == 0) ? m0_reg_space : m1_reg_space;
          md_adr  = (md_owner == 0) ? m0_adr : m1_adr;
          md_left = ((md_owner == 0) ? int'(m0_len) : int'(m1_len)) + 1;
          md_granted = 1; md_phase = 1;
        end
      end else if (md_phase == 1) begin
        if (md_we ? hb_ready_i : hb_valid_i) begin
          md_left--;
          if (md_left == 0) md_phase = 2;
        end
      end else if (md_phase == 2) begin
        if (!hb_busy_i) begin
          md_done[md_owner] = 1; md_granted = 0; md_ptr = md_owner; md_phase = 0;
        end
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin : cmp
    logic [12:0] act, exp;
    bit x0, x1;
    if (chk_en && !rst) begin
      x0 = md_phase == 1 && md_owner == 0;
      x1 = md_phase == 1 && md_owner == 1;
      act = {m1_gnt, m0_gnt, hb_wrq_o, hb_rrq_o, m1_done, m0_done, m1_err, m0_err, err_o,
             m1_wready, m0_wready, m1_rvalid, m0_rvalid};
      exp = {md_granted && md_owner == 1, md_granted && md_owner == 0,
             md_phase == 1 && md_we, md_phase == 1 && !md_we,
             md_done[1], md_done[0], md_err[1], md_err[0], md_err_sticky,
             x1 && md_we && hb_ready_i, x0 && md_we && hb_ready_i,
             x1 && !md_we && hb_valid_i, x0 && !md_we && hb_valid_i};
      check("ctrl", 64'(act), 64'(exp));
      check("hb_dat", 64'(hb_dat_o), !md_granted ? 64'd0 : (md_owner == 0 ? 64'(m0_wdat) : 64'(m1_wdat)));
      check("hb_mask", 64'(hb_mask_o), !md_granted ? 64'd0 : (md_owner == 0 ? 64'(m0_wmask) : 64'(m1_wmask)));
      check("rdat", 64'({m1_rdat, m0_rdat}), 64'({hb_dat_i, hb_dat_i}));
      if (md_granted) check("cmd", 64'({hb_reg_space_o, hb_adr_o}), 64'({md_reg, md_adr}));
    end
  end

  // Observation counters used by the directed checks.
  int wr_cnt[2], rv_cnt[2], done_cnt[2], done_err_cnt[2];
  int both_gnt, m0_act, valid_sent;
  logic [DW-1:0] last_rdat[2];
  int order[$];
  logic prev_g0 = 0, prev_g1 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_wready) wr_cnt[0]++;
      if (m1_wready) wr_cnt[1]++;
      if (m0_rvalid) begin rv_cnt[0]++; last_rdat[0] = m0_rdat; end
      if (m1_rvalid) begin rv_cnt[1]++; last_rdat[1] = m1_rdat; end
      if (m0_done) begin done_cnt[0]++; if (m0_err) done_err_cnt[0]++; end
      if (m1_done) begin done_cnt[1]++; if (m1_err) done_err_cnt[1]++; end
      if (m0_gnt && m1_gnt) both_gnt++;
      if (m0_gnt && !prev_g0) order.push_back(0);
      if (m1_gnt && !prev_g1) order.push_back(1);
      if (m0_gnt || m0_wready || m0_rvalid || m0_done || m0_err) m0_act++;
    end
    prev_g0 = m0_gnt;
    prev_g1 = m1_gnt;
  end

  task automatic clr_mon();
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0; rv_cnt[i] = 0; done_cnt[i] = 0; done_err_cnt[i] = 0;
    end
    both_gnt = 0; m0_act = 0; valid_sent = 0;
    order.delete();
  endtask

  // Controller model and per-cycle data scrambling.
  int ready_pct = 100, valid_pct = 100, extra = 0, extra_left = 0, tail_cfg = 2, tail_left = 0;
  bit fixed_dat = 0;
  logic [DW-1:0] fixed_val = '0;
  bit prev_rq = 0;
  always @(posedge clk) begin : ctrl
    bit rq_now;
    #1;
    m0_wdat = DW'($urandom); m1_wdat = DW'($urandom);
    m0_wmask = MW'($urandom); m1_wmask = MW'($urandom);
    hb_dat_i = fixed_dat ? fixed_val : DW'($urandom);
    rq_now = hb_wrq_o || hb_rrq_o;
    if (prev_rq && !rq_now) begin extra_left = extra; tail_left = tail_cfg; end
    prev_rq = rq_now;
    hb_ready_i = hb_wrq_o && ($urandom_range(99) < ready_pct);
    if (hb_rrq_o) hb_valid_i = ($urandom_range(99) < valid_pct);
    else begin
      hb_valid_i = (extra_left > 0);
      if (extra_left > 0) extra_left--;
    end
    if (hb_valid_i) valid_sent++;
    hb_busy_i = rq_now || tail_left > 0;
    if (!rq_now && tail_left > 0) tail_left--;
    if (m0_done) m0_req = 0;
    if (m1_done) m1_req = 0;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic issue(input int p, input bit we, input int len, input logic [AW-1:0] adr);
    if (p == 0) begin
      m0_we = we; m0_len = BW'(len); m0_adr = adr; m0_reg_space = 1'($urandom); m0_req = 1;
    end else begin
      m1_we = we; m1_len = BW'(len); m1_adr = adr; m1_reg_space = 1'($urandom); m1_req = 1;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((m0_req || m1_req) && n < budget) begin step(1); n++; end
    check({name, "_complete"}, 64'(m0_req || m1_req), 64'd0);
    step(1);
  endtask

  initial begin
    rst = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_reg_space = 0; m1_reg_space = 0;
    m0_adr = '0; m1_adr = '0; m0_len = '0; m1_len = '0; m0_wdat = '0; m1_wdat = '0;
    m0_wmask = '0; m1_wmask = '0; hb_dat_i = '0; hb_ready_i = 0; hb_valid_i = 0;
    hb_busy_i = 0; hb_error_i = 0;
    clr_mon();
    step(2);
    check("reset_ctrl", 64'({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_wready, m1_wready,
                              m0_rvalid, m1_rvalid, hb_wrq_o, hb_rrq_o, err_o, hb_reg_space_o, hb_mask_o}), 64'd0);
    check("reset_data", 64'({hb_adr_o, hb_dat_o}), 64'd0);
    rst = 0; chk_en = 1;
    step(1);

    // Write burst, m0, 4 words at 0x100.
    clr_mon(); ready_pct = 100; tail_cfg = 2;
    issue(0, 1, 3, 32'h100);
    step(1);
    check("wr_wrq_up", 64'(hb_wrq_o), 64'd1);
    check("wr_adr", 64'(hb_adr_o), 64'h100);
    wait_idle(50, "wr");
    check("wr_wready_cnt", 64'(wr_cnt[0]), 64'd4);
    check("wr_done_cnt", 64'(done_cnt[0]), 64'd1);

    // Single-word read on m1 with gaps.
    clr_mon(); valid_pct = 30; fixed_dat = 1; fixed_val = 16'hBEEF;
    issue(1, 0, 0, 32'h2000);
    wait_idle(300, "rd");
    fixed_dat = 0;
    check("rd_rvalid_cnt", 64'(rv_cnt[1]), 64'd1);
    check("rd_rdat", 64'(last_rdat[1]), 64'hBEEF);
    check("rd_done_cnt", 64'(done_cnt[1]), 64'd1);
    check("rd_m0_quiet", 64'(m0_act), 64'd0);

    // Contention: both ports request together, twice.
    clr_mon(); valid_pct = 100; ready_pct = 100;
    repeat (2) begin
      issue(0, 1, 1, 32'h10);
      issue(1, 0, 2, 32'h20);
      wait_idle(200, "cont");
    end
    check("cont_grants", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("cont_order", 64'((i < order.size()) ? order[i] : 9), 64'(i % 2));
    check("cont_both_gnt", 64'(both_gnt), 64'd0);

    // Over-delivery: 2-word read, controller sends a third valid.
    clr_mon(); extra = 1;
    issue(0, 0, 1, 32'h300);
    wait_idle(50, "od");
    extra = 0;
    check("od_rvalid_cnt", 64'(rv_cnt[0]), 64'd2);
    check("od_valids_sent", 64'(valid_sent), 64'd3);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      int pick;
      ready_pct = $urandom_range(30, 100); valid_pct = $urandom_range(30, 100);
      tail_cfg = $urandom_range(0, 3); extra = $urandom_range(0, 1);
      pick = $urandom_range(1, 3);
      if ((pick & 1) != 0) issue(0, 1'($urandom), $urandom_range(0, 7), $urandom);
      if ((pick & 2) != 0) issue(1, 1'($urandom), $urandom_range(0, 7), $urandom);
      wait_idle(400, "rand");
    end
    extra = 0;

    // Reset in the middle of a read.
    clr_mon(); valid_pct = 0;
    issue(0, 0, 3, 32'h40);
    step(3);
    check("rstmid_pre", 64'(hb_rrq_o), 64'd1);
    rst = 1; #1;
    check("rstmid_ctrl", 64'({m0_gnt, m1_gnt, m0_done, m0_err, hb_wrq_o, hb_rrq_o, err_o, hb_mask_o}), 64'd0);
    check("rstmid_data", 64'({hb_adr_o, hb_dat_o}), 64'd0);
    m0_req = 0;
    step(2);
    rst = 0; valid_pct = 100;
    step(3);
    check("rstmid_no_done", 64'(done_cnt[0]), 64'd0);

    // Controller error mid-burst.
    clr_mon(); valid_pct = 20;
    issue(0, 0, 7, 32'h80);
    step(3);
    hb_error_i = 1;
    step(1);
    hb_error_i = 0;
    step(2);
    check("err_done", 64'(done_cnt[0]), 64'd1);
    check("err_done_err", 64'(done_err_cnt[0]), 64'd1);
    check("err_sticky", 64'(err_o), 64'd1);
    order.delete();
    issue(1, 1, 0, 32'h90);
    step(20);
    check("err_no_grant", 64'(order.size()), 64'd0);
    check("err_still", 64'(err_o), 64'd1);
    m1_req = 0; rst = 1;
    step(2);
    rst = 0; valid_pct = 100;
    step(1);

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    begin
      int rq_hi = 0, n = 0;
      chk_en = 0; clr_mon(); valid_pct = 0; tail_cfg = 1;
      issue(0, 0, 2, 32'hA0);
      while (m0_req && n < 200) begin step(1); n++; if (hb_rrq_o) rq_hi++; end
      check("to_rrq_cycles", 64'(rq_hi), 64'(TO));
      step(1);
      check("to_done_err", 64'(done_err_cnt[0]), 64'd1);
      rst = 1; m0_req = 0;
      step(2);
      rst = 0; valid_pct = 100; chk_en = 1;
      step(1);
    end
`endif

    step(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Two-port round-robin arbiter and burst sequencer in front of the `hyperbus` primary controller. It grants one of two requesters at a time (e.g. CPU port 0, DMA port 1) and latches that requester's command. It drives the controller's held-high `wrq`/`rrq`, counts the burst's words on `ready`/`valid`, and drops the request after the last word. It then waits for the controller to return idle before re-arbitrating.

## Interface
Parameters:
- `WIDTH`, 8, HyperBus DQ width; word = 2*WIDTH bits.
- `ADDR_LENGTH`, 32, address width.
- `BURST_WIDTH`, 4, burst length field width; burst = `len`+1 words, 1..2^BURST_WIDTH.
- `TIMEOUT_COUNT`, 64, idle cycles in XFER before abort (only with the timeout macro).

Ports (`n` = 0,1; MW = (2*WIDTH/8)+1):
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mn_req` in 1: request. Hold high until `mn_done`.
- `mn_we` in 1: 1 = write, 0 = read.
- `mn_reg_space` in 1: register space select.
- `mn_adr` in ADDR_LENGTH: start address.
- `mn_len` in BURST_WIDTH: word count minus 1.
- `mn_wdat` in 2*WIDTH: write word.
- `mn_wmask` in MW: write mask.
- `mn_wready` out 1: write word accepted this cycle.
- `mn_rdat` out 2*WIDTH: read word.
- `mn_rvalid` out 1: `mn_rdat` is valid.
- `mn_gnt` out 1: port owns the controller.
- `mn_done` out 1: one-cycle completion pulse.
- `mn_err` out 1: qualifies `mn_done`; the burst aborted.
- `hb_adr_o` out ADDR_LENGTH, `hb_dat_o` out 2*WIDTH, `hb_mask_o` out MW, `hb_reg_space_o` out 1, `hb_wrq_o` out 1, `hb_rrq_o` out 1: controller command and write data.
- `hb_dat_i` in 2*WIDTH, `hb_ready_i` in 1, `hb_valid_i` in 1, `hb_busy_i` in 1, `hb_error_i` in 1: controller status and read data.
- `err_o` out 1: sticky; the controller is in its error state.

## Operation
- States: IDLE, XFER, DRAIN, ERROR.
- IDLE:
  - If any `mn_req` is high: grant it and latch `we`, `reg_space`, `adr`, `len`. Load the word counter with `len`, assert `hb_wrq_o` or `hb_rrq_o`, then go to XFER.
  - If both request: grant the port not granted last. The last-grant pointer resets to port 1, so port 0 wins first.
- XFER:
  - Write: each cycle with `hb_ready_i`, one word is consumed and `mn_wready` pulses.
  - Read: each cycle with `hb_valid_i`, `mn_rvalid` pulses.
  - The counter decrements per word. At the word where the counter is 0, drop wrq/rrq next cycle and go to DRAIN.
- DRAIN: wait for `hb_busy_i`=0. Then pulse `mn_done` (err=0), drop `mn_gnt`, update the pointer, and return to IDLE.
- ERROR: entered from any state when `hb_error_i`=1.
  - Drop wrq/rrq. If a burst is active, pulse that port's `mn_done` with `mn_err`=1.
  - Set `err_o`. Stay in ERROR until `rst`; no further grants.
- Datapath:
  - `hb_dat_o`/`hb_mask_o` combinationally mux the granted port's `wdat`/`wmask`. They are zero when no port is granted.
  - `mn_rdat` = `hb_dat_i` for both ports.
  - `mn_rvalid` = `hb_valid_i` & granted & XFER & read.
  - `mn_wready` = `hb_ready_i` & granted & XFER & write.
- Extra controller words after the count reaches 0 are ignored, and no strobe reaches the requester.
- Requests arriving in DRAIN or ERROR wait; they are never lost.

## Timing
- Reset values: all outputs 0. State IDLE, counter 0, pointer = 1.
- Grant: `mn_gnt`, `hb_*rq_o` and `hb_adr_o` are registered and go high 1 cycle after `mn_req` is sampled in IDLE.
- Data strobes: `mn_wready`/`mn_rvalid` have zero latency, in the same cycle as `hb_ready_i`/`hb_valid_i`.
- Request drop: wrq/rrq go low 1 cycle after the last word's strobe.
- Completion: `mn_done` is 1 cycle wide, in the cycle after `hb_busy_i` is sampled low in DRAIN.
- Re-arbitration: the earliest next grant is the cycle after `mn_done`. The controller's own idle cooldown absorbs an early request.
- Reset mid-burst: everything is cleared asynchronously, and no `done` is issued.

## Configuration
- Macro: `HYPERBUS_ARB_TIMEOUT_EN`.
- Defined:
  - A watchdog counter runs in XFER and clears on every word strobe.
  - When it reaches TIMEOUT_COUNT, drop wrq/rrq, flag an abort, and go to DRAIN.
  - DRAIN then pulses `mn_done` with `mn_err`=1.
- Undefined: no watchdog, and XFER waits indefinitely.

## Structure
- Package `hyperbus_arb_pkg`: state enum (one-hot, 4 states), port index type, and the reset pointer constant.
- Sub-module `hyperbus_rr_arb`: 2-way round-robin picker (`req[1:0]`, `last`, `gnt[1:0]`). It is combinational, and the pointer register lives in the top level.

## Test plan
- Write burst: m0 requests a write with `len`=3 and `adr`=0x100, and the controller model gives `hb_ready_i` for 4 cycles.
  - `hb_wrq_o` is high 1 cycle after request, with `hb_adr_o`=0x100.
  - 4 `m0_wready` pulses, and `hb_wrq_o` low after the 4th.
  - `m0_done` after busy falls.
- Read burst: m1 requests a read with `len`=0, and the model returns one word 0xBEEF with gaps.
  - `m1_rvalid` is 1 cycle wide with `m1_rdat`=0xBEEF, then `m1_done`.
  - m0 outputs stay 0.
- Contention: both ports request in the same cycle, repeatedly.
  - Grant order is m0, m1, m0, m1.
  - `gnt` is never high on both ports.
- Over-delivery: `len`=1 and the model sends 3 valids. Only 2 `rvalid` pulses occur, with no third.
- Controller error: raise `hb_error_i` mid-burst.
  - Owner gets `done`=1 with `err`=1, and `err_o` stays high.
  - A new `req` gets no grant until `rst`.
- Timeout and reset, with `HYPERBUS_ARB_TIMEOUT_EN` defined: a read with no valids for 64 cycles.
  - `hb_rrq_o` drops and `m0_done` comes with `m0_err`=1.
  - Asserting `rst` mid-XFER zeroes all outputs at once.
